// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a bank of 7-segment digits that share
// one code-to-segment decoder. It holds one 4-bit code per digit position and
// walks the positions in order. Each position gets a dark BLANK gap and then a
// lit SHOW window. During the window the position's code drives the decoder
// and only that digit is enabled. All outputs come straight from flops.
module display_scan_ctrl #(
    parameter int DIGITS      = 4,  // multiplexed digit positions (2..8)
    parameter int REFRESH_DIV = 4,  // cycles each digit is lit
    parameter int BLANK_CYC   = 1   // dark cycles between digits
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    output logic              wr_ack,
    output logic [3:0]        code,
    output logic [DIGITS-1:0] digit_en,
    output logic              frame_tick
);

    // One counter serves both BLANK and SHOW, so it is sized for the longer
    // of the two phases. It is cleared on every phase change and never wraps.
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_SHOW  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [3:0]       DIG_LIMIT  = 4'(DIGITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   nxt_idx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               nxt_tick;
    logic [DIGITS-1:0]  nxt_digit_en;
    logic [3:0]         buf_q [DIGITS];
    logic               wr_hit;

    // Writes to positions that do not exist are ignored and are not acknowledged.
    assign wr_hit = wr_en && ({1'b0, wr_addr} < DIG_LIMIT);

    // Code buffer and write acknowledge. These do not depend on the scan state,
    // so a write and a scan transition on the same edge do not interact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                buf_q[i] <= 4'd0;
            end
            wr_ack <= 1'b0;
        end else begin
            if (wr_hit) begin
                buf_q[wr_addr[IDX_W-1:0]] <= wr_data;
            end
            wr_ack <= wr_hit;
        end
    end

    // Next-state logic. Dropping enable always returns to IDLE at digit 0.
    // A restart therefore begins with a full BLANK before digit 0.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        nxt_tick  = 1'b0;
        if (!enable) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
                BLANK: begin
                    if (cnt == LAST_BLANK) begin
                        nxt_state = SHOW;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt == LAST_SHOW) begin
                        nxt_state = BLANK;
                        nxt_cnt   = '0;
                        if (idx == LAST_IDX) begin
                            nxt_idx  = '0;
                            nxt_tick = 1'b1;
                        end else begin
                            nxt_idx = idx + 1'b1;
                        end
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    nxt_idx   = '0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Digit enable is decoded from the next state, so the registered enable
    // lines up exactly with the state it belongs to. Only SHOW lights a digit.
    always_comb begin
        nxt_digit_en = '0;
        if (nxt_state == SHOW) begin
            nxt_digit_en[nxt_idx] = 1'b1;
        end
    end

    // State register plus the registered scan outputs. The code register
    // samples the buffer entry of the current position every active cycle.
    // A write to the lit digit therefore reaches the decoder one edge after
    // the buffer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            code       <= 4'd0;
            digit_en   <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            digit_en   <= nxt_digit_en;
            frame_tick <= nxt_tick;
            code       <= (nxt_state == IDLE) ? 4'd0 : buf_q[idx];
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl. The reference model describes the scan as a
// position inside a repeating frame. Each digit owns one slot of
// BLANK_CYC + REFRESH_DIV cycles, and the first BLANK_CYC cycles of a slot
// are dark.
module tb_display_scan_ctrl;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int BLANK_CYC   = 1;
    localparam int SLOT        = BLANK_CYC + REFRESH_DIV;
    localparam int PERIOD      = DIGITS * SLOT;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [3:0]        wr_data;
    logic              wr_ack;
    logic [3:0]        code;
    logic [DIGITS-1:0] digit_en;
    logic              frame_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: scanning flag, cycles since scan start, and the
    // contents of the code buffer.
    bit                m_scan;
    int                m_t;
    logic [3:0]        mbuf [DIGITS];
    logic [DIGITS-1:0] prev_en;

    display_scan_ctrl #(
        .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .code(code),
        .digit_en(digit_en), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_digit();
        return m_scan ? (m_t % PERIOD) / SLOT : 0;
    endfunction

    function automatic bit m_lit();
        return m_scan && (((m_t % PERIOD) % SLOT) >= BLANK_CYC);
    endfunction

    task automatic m_reset();
        m_scan  = 1'b0;
        m_t     = 0;
        prev_en = '0;
        for (int i = 0; i < DIGITS; i++) mbuf[i] = 4'd0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_code"},  32'(code),       32'd0);
        chk({tag, "_den"},   32'(digit_en),   32'd0);
        chk({tag, "_ack"},   32'(wr_ack),     32'd0);
        chk({tag, "_tick"},  32'(frame_tick), 32'd0);
    endtask

    // Apply one cycle of inputs, advance the model across the edge and compare.
    task automatic step(input logic en, input logic we, input logic [2:0] wa, input logic [3:0] wd);
        int                rd;
        logic              e_ack;
        logic [3:0]        e_code;
        logic [DIGITS-1:0] e_en;
        logic              e_tick;
        enable  = en;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        rd    = m_digit();
        e_ack = we && (int'(wa) < DIGITS);
        if (en) begin
            if (m_scan) m_t++;
            else begin
                m_scan = 1'b1;
                m_t    = 0;
            end
        end else begin
            m_scan = 1'b0;
        end
        e_code = m_scan ? mbuf[rd] : 4'd0;
        if (e_ack) mbuf[int'(wa)] = wd;
        e_en = '0;
        if (m_lit()) e_en[m_digit()] = 1'b1;
        e_tick = m_scan && (m_t > 0) && ((m_t % PERIOD) == 0);
        #1;
        chk("wr_ack",     32'(wr_ack),     32'(e_ack));
        chk("code",       32'(code),       32'(e_code));
        chk("digit_en",   32'(digit_en),   32'(e_en));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
        chk("onehot",     32'($countones(digit_en) <= 1), 32'd1);
        chk("dark_gap",   32'((prev_en != '0) && (digit_en != '0) && (digit_en != prev_en)), 32'd0);
        prev_en = digit_en;
    endtask

    // Scan until the model says digit d has just become lit; bounded.
    task automatic wait_lit(input int d);
        int n = 0;
        while (!(m_lit() && m_digit() == d) && n < 4 * PERIOD) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            n++;
        end
        chk("wait_lit", 32'(m_lit() && m_digit() == d), 32'd1);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 3'd0;
        wr_data = 4'd0;
        m_reset();
        @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        repeat (3) step(1'b0, 1'b0, 3'd0, 4'd0);

        // Load codes 1..4 and run two full frames.
        for (int i = 0; i < DIGITS; i++) step(1'b0, 1'b1, 3'(i), 4'(i + 1));
        step(1'b0, 1'b0, 3'd0, 4'd0);
        repeat (2 * PERIOD) step(1'b1, 1'b0, 3'd0, 4'd0);

        // Out-of-range address is neither stored nor acknowledged.
        step(1'b1, 1'b1, 3'd5, 4'd7);
        step(1'b1, 1'b1, 3'd7, 4'd7);
        repeat (PERIOD) step(1'b1, 1'b0, 3'd0, 4'd0);

        // Rewrite the digit that is currently lit.
        wait_lit(1);
        step(1'b1, 1'b1, 3'd1, 4'd9);
        repeat (PERIOD) step(1'b1, 1'b0, 3'd0, 4'd0);

        // Drop enable while digit 3 is lit, then restart three cycles later.
        wait_lit(3);
        repeat (3) step(1'b0, 1'b0, 3'd0, 4'd0);
        repeat (PERIOD + 5) step(1'b1, 1'b0, 3'd0, 4'd0);

        // Random traffic: mostly scanning, occasional enable drops, any address.
        repeat (3000) step(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
                           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));

        // Asynchronous reset in the middle of digit 2's window.
        wait_lit(2);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        m_reset();
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        reset = 1'b0;
        repeat (4) step(1'b0, 1'b0, 3'd0, 4'd0);
        // The buffer was cleared, so a scan now presents zero codes.
        repeat (PERIOD + 3) step(1'b1, 1'b0, 3'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
